// File: rtl/serial_alu_pkg.sv
// Shared types and widths for the serial CPU execute stage.
package cpu_pkg;
  localparam int unsigned XLEN      = 16;
  localparam int unsigned REG_IDX_W = 3;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_PASSB = 3'd5,
    OP_SLT   = 3'd6,
    OP_SLTU  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} alu_state_t;

  // Ops that run through the adder as a+~b+1.
  function automatic logic op_inverts_b(alu_op_t op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction
endpackage

// File: rtl/serial_alu_if.sv
// Decode-to-ALU handshake and register-file write-back bundle.
interface serial_alu_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) ();
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [REG_IDX_W-1:0] rd_in;
  logic                 ready;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic [REG_IDX_W-1:0] rd_out;
  logic                 carry;
  logic                 zero;

  modport master (
    output start, op, a, b, rd_in,
    input  ready, done, result, rd_out, carry, zero
  );

  modport slave (
    input  start, op, a, b, rd_in,
    output ready, done, result, rd_out, carry, zero
  );
endinterface

// File: rtl/serial_alu_fa.sv
// One-bit full adder with a registered carry that can be preloaded.
module serial_fa (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic init,
  input  logic en,
  input  logic x,
  input  logic y,
  output logic sum,
  output logic cout,
  output logic c
);
  assign sum  = x ^ y ^ c;
  assign cout = (x & y) | (c & (x ^ y));

  always_ff @(posedge clk) begin
    if (rst) begin
      c <= 1'b0;
    end else if (load) begin
      c <= init;
    end else if (en) begin
      c <= cout;
    end
  end
endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: operands are consumed LSB-first, one bit per clock.
module serial_alu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input logic       clk,
  input logic       rst,
  serial_alu_if.slave bus
);
  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  alu_state_t           state;
  alu_op_t              op_q;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-2:0]     res_sh;
  logic [REG_IDX_W-1:0] rd_q;
  logic [CW-1:0]        cnt;

  logic fa_load, fa_init, fa_en, fa_y, fa_sum, fa_cout, fa_c;
  logic res_bit, lt;
  logic [WIDTH-1:0] last_res;
  logic [WIDTH-1:0] final_res;

  assign fa_load = (state == IDLE) && bus.start;
  assign fa_init = op_inverts_b(alu_op_t'(bus.op));
  assign fa_en   = (state == RUN);
  assign fa_y    = b_sh[0] ^ op_inverts_b(op_q);

  serial_fa u_fa (
    .clk  (clk),
    .rst  (rst),
    .load (fa_load),
    .init (fa_init),
    .en   (fa_en),
    .x    (a_sh[0]),
    .y    (fa_y),
    .sum  (fa_sum),
    .cout (fa_cout),
    .c    (fa_c)
  );

  always_comb begin
    res_bit = fa_sum;
    unique case (op_q)
      OP_AND:   res_bit = a_sh[0] & b_sh[0];
      OP_OR:    res_bit = a_sh[0] | b_sh[0];
      OP_XOR:   res_bit = a_sh[0] ^ b_sh[0];
      OP_PASSB: res_bit = b_sh[0];
      default:  res_bit = fa_sum;
    endcase
    last_res = {res_bit, res_sh};

    // On the MSB cycle fa_c is the carry into the sign bit, so the XOR with
    // the carry-out is the signed overflow flag.
    lt = (op_q == OP_SLTU) ? ~fa_cout : (fa_sum ^ (fa_c ^ fa_cout));

    final_res = last_res;
    if ((op_q == OP_SLT) || (op_q == OP_SLTU)) begin
      final_res    = '0;
      final_res[0] = lt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      rd_q       <= '0;
      cnt        <= '0;
      bus.ready  <= 1'b1;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
      bus.carry  <= 1'b0;
      bus.zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh      <= bus.a;
            b_sh      <= bus.b;
            op_q      <= alu_op_t'(bus.op);
            rd_q      <= bus.rd_in;
            res_sh    <= '0;
            cnt       <= '0;
            bus.ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= last_res[WIDTH-1:1];
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt        <= '0;
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.result <= final_res;
            bus.rd_out <= rd_q;
            bus.carry  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? fa_cout : 1'b0;
            bus.zero   <= (final_res == '0);
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial execute stage of the 16-bit serial CPU. It accepts two operands read from the register file, processes them LSB-first at one bit per clock, and then presents a 16-bit result with its destination index. `done` acts as the write enable for the register-file write port. One operation is in flight at a time, with a simple ready/start handshake toward decode.

## Interface
Parameters:
- `WIDTH`, default 16: operand/result width; also the number of RUN cycles.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; accepted only when `ready`=1.
- `op` input 3: operation, sampled at acceptance (encoding below).
- `a` input WIDTH: operand A (rs1 data), sampled at acceptance.
- `b` input WIDTH: operand B (rs2 data), sampled at acceptance.
- `rd_in` input 3: destination register index, sampled at acceptance.
- `ready` output 1: 1 only in IDLE.
- `done` output 1: one-cycle pulse; `result`/`rd_out` are valid and must be written back.
- `result` output WIDTH: operation result.
- `rd_out` output 3: destination index captured with the operation.
- `carry` output 1: final carry-out for ADD/SUB; 0 for all other ops.
- `zero` output 1: 1 when `result`==0.

## Operation
- Op encoding:
  - 0 ADD: a+b.
  - 1 SUB: a+~b+1; `carry`=1 means no borrow.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 PASSB: result = b.
  - 6 SLT: signed a<b, result 16'h0001 or 16'h0000.
  - 7 SLTU: unsigned a<b, same result format.
- FSM has three states:
  - IDLE: `ready`=1. If `start`=1, capture a, b, op and rd_in into shift and hold registers; carry flop ← 1 for SUB/SLT/SLTU, else 0; bit counter ← 0; go to RUN.
  - RUN: each cycle compute the bit from a_sh[0], b_sh[0] (b inverted for SUB/SLT/SLTU) and the carry flop. Shift the result bit in at the MSB of the result shift register, shift a_sh/b_sh right, update carry and increment the counter. On the cycle with counter==WIDTH-1, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- SLT/SLTU finalisation at the last RUN bit:
  - SLTU: lt = ~carry_out.
  - SLT: lt = diff_msb ^ (carry_in_msb ^ carry_out).
  - `result` = {WIDTH-1 zeros, lt}.
- Output registers:
  - `result`, `rd_out`, `carry` and `zero` update only on the RUN→DONE edge and hold until the next completion.
  - `zero` is computed on the final result value, after SLT/SLTU substitution.
- `start` in RUN or DONE: ignored, no queuing. Operand changes after acceptance have no effect.
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, `rd_out`=0, `carry`=0, `zero`=0, counter=0.
- `rst` mid-RUN aborts the operation. No `done` is issued and the FSM is in IDLE on the next cycle. `rst` has priority over `start` in the same cycle.

## Timing
- Acceptance edge E0 (IDLE and `start`).
- RUN spans the cycles after E0 through edge E16; `done`=1 in the cycle after E16.
- Latency from acceptance to `done`: WIDTH clocks. Initiation interval: WIDTH+2 clocks. `ready` returns the cycle after `done`.
- `start` held high continuously gives back-to-back operations every WIDTH+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs except through state.

## Structure
- `cpu_pkg` holds:
  - `alu_op_t` enum (3 bits, values above).
  - `alu_state_t` enum {IDLE, RUN, DONE}.
  - `XLEN`=16 and `REG_IDX_W`=3.
- Sub-module `serial_fa`: 1-bit full adder with registered carry, plus load/init value and enable. Instantiated once. Bitwise ops bypass it via a per-bit mux in the parent.
- Counter width is $clog2(WIDTH).

## Test plan
- ADD a=16'h7FFF, b=16'h0001, rd_in=3 → `done` exactly 16 cycles after acceptance, result=16'h8000, carry=0, zero=0, rd_out=3.
- SUB a=16'h0005, b=16'h0005 → result=0, zero=1, carry=1. SUB a=0, b=1 → result=16'hFFFF, carry=0.
- SLT a=16'hFFFF, b=16'h0001 → result=1. SLTU with the same operands → result=0, zero=1. SLT a=16'h8000, b=16'h7FFF → 1 (overflow case).
- AND/OR/XOR/PASSB with a=16'hF0F0, b=16'h3C3C → 16'h3030, 16'hFCFC, 16'hCCCC, 16'h3C3C. carry=0 for all.
- `start` pulsed at RUN cycle 5 with new operands, and `a` changed mid-RUN → first result unaffected, second request not executed. `start` held high continuously → completions every 18 cycles.
- `rst` asserted at RUN cycle 8 → no `done`, all outputs at reset values, `ready`=1 the next cycle. A fresh ADD then completes correctly.
